tlcd_responder: RTL

//  HD44780-compatible write-side responder for the TLCD bus that the text and font-loader drivers emit.
//  - Synchronizes E/RS/RW/DATA and latches each byte on the falling edge of E.
//  - Decodes commands and data writes into a 2x16 DDRAM shadow, exposed as two flat 128-bit lines.
//  - Used on-board as a display mirror/monitor and as the scoreboard end of LCD driver benches.

---
 rtl/tlcd_pkg.sv | 54 +++++
 rtl/tlcd_bus_sync.sv | 59 +++++
 rtl/tlcd_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tlcd_pkg.sv
// tlcd_pkg: shared opcodes, DDRAM geometry and address-counter stepping for the
// TLCD write-side responder.
package tlcd_pkg;

  // Address-counter target selected by the most recent set-address command.
  typedef enum logic {
    TGT_DDRAM = 1'b0,
    TGT_CGRAM = 1'b1
  } target_t;

  // Command opcodes; the highest set bit of a command byte identifies it.
  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_HOME   = 8'h02;
  localparam logic [7:0] CMD_ENTRY  = 8'h04;
  localparam logic [7:0] CMD_DISP   = 8'h08;
  localparam logic [7:0] CMD_SHIFT  = 8'h10;
  localparam logic [7:0] CMD_FUNC   = 8'h20;
  localparam logic [7:0] CMD_CGADDR = 8'h40;
  localparam logic [7:0] CMD_DDADDR = 8'h80;

  // Field bit positions inside the commands that carry flags.
  localparam int ENTRY_I_BIT = 1;
  localparam int DISP_D_BIT  = 2;
  localparam int SHIFT_R_BIT = 2;
  localparam int SHIFT_S_BIT = 3;
  localparam int FUNC_N_BIT  = 3;

  // DDRAM geometry of the two-line panel.
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [6:0] ROW0_BASE  = 7'h00;
  localparam logic [6:0] ROW1_BASE  = 7'h40;
  localparam logic [6:0] ROW0_LAST  = 7'h27;
  localparam logic [6:0] ROW1_LAST  = 7'h67;

  // Step the address counter one position with HD44780 row wrapping in DDRAM
  // and plain modulo-64 stepping in CGRAM.
  function automatic logic [6:0] next_ac(input logic [6:0] ac, input logic incr,
                                         input target_t target);
    logic [6:0] res;
    if (target == TGT_CGRAM) begin
      res = incr ? {1'b0, ac[5:0] + 6'd1} : {1'b0, ac[5:0] - 6'd1};
    end else if (incr) begin
      if (ac == ROW0_LAST)      res = ROW1_BASE;
      else if (ac == ROW1_LAST) res = ROW0_BASE;
      else                      res = ac + 7'd1;
    end else begin
      if (ac == ROW0_BASE)      res = ROW1_LAST;
      else if (ac == ROW1_BASE) res = ROW0_LAST;
      else                      res = ac - 7'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tlcd_bus_sync.sv
// tlcd_bus_sync: brings the asynchronous TLCD bus into the CLK domain and flags
// each falling edge of E together with the RS/RW/DATA sampled alongside it.
module tlcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       e_in,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [7:0] data_in,
  output logic       fall,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);

  // E carries one extra stage so the edge detector can compare two ages.
  logic [SYNC_STAGES:0]   e_q, e_d;
  logic [SYNC_STAGES-1:0] rs_q, rs_d;
  logic [SYNC_STAGES-1:0] rw_q, rw_d;
  logic [7:0]             data_q [SYNC_STAGES];
  logic [7:0]             data_d [SYNC_STAGES];

  // Shift every bus signal one stage deeper each clock.
  always_comb begin
    e_d[0]    = e_in;
    rs_d[0]   = rs_in;
    rw_d[0]   = rw_in;
    data_d[0] = data_in;
    for (int i = 1; i <= SYNC_STAGES; i++) e_d[i] = e_q[i-1];
    for (int i = 1; i < SYNC_STAGES; i++) begin
      rs_d[i]   = rs_q[i-1];
      rw_d[i]   = rw_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Synchronizer flops clear to 0 so an E held high through reset never looks like a fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_q  <= '0;
      rs_q <= '0;
      rw_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_q[i] <= '0;
    end else begin
      e_q  <= e_d;
      rs_q <= rs_d;
      rw_q <= rw_d;
      for (int i = 0; i < SYNC_STAGES; i++) data_q[i] <= data_d[i];
    end
  end

  assign fall = ~e_q[SYNC_STAGES-1] & e_q[SYNC_STAGES];
  assign rs   = rs_q[SYNC_STAGES-1];
  assign rw   = rw_q[SYNC_STAGES-1];
  assign data = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/tlcd_responder.sv
// tlcd_responder: HD44780-style write-side responder that mirrors a 2x16 DDRAM
// from the TLCD bus. Define TLCD_CGRAM_EN to add a 64x8 CGRAM store with a
// combinational read port (CG_RADDR/CG_RDATA).
module tlcd_responder
  import tlcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LINE_CHARS  = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         TLCD_E,
  input  logic         TLCD_RS,
  input  logic         TLCD_RW,
  input  logic [7:0]   TLCD_DATA,
  output logic [127:0] LINE0,
  output logic [127:0] LINE1,
  output logic [6:0]   AC,
  output logic         DISPLAY_ON,
  output logic         TWO_LINE,
  output logic         CMD_STROBE,
  output logic         DATA_STROBE,
  output logic [7:0]   LAST_BYTE,
  output logic         LINE_DONE,
  output logic [7:0]   RD_IGNORED
`ifdef TLCD_CGRAM_EN
  ,
  input  logic [5:0]   CG_RADDR,
  output logic [7:0]   CG_RDATA
`endif
);

  logic       bus_fall;
  logic       bus_rs;
  logic       bus_rw;
  logic [7:0] bus_data;

  tlcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .e_in    (TLCD_E),
    .rs_in   (TLCD_RS),
    .rw_in   (TLCD_RW),
    .data_in (TLCD_DATA),
    .fall    (bus_fall),
    .rs      (bus_rs),
    .rw      (bus_rw),
    .data    (bus_data)
  );

  logic [127:0] line0_q, line0_d;
  logic [127:0] line1_q, line1_d;
  logic [6:0]   ac_q, ac_d;
  logic         incr_q, incr_d;
  target_t      target_q, target_d;
  logic         display_on_q, display_on_d;
  logic         two_line_q, two_line_d;
  logic         cmd_strobe_q, cmd_strobe_d;
  logic         data_strobe_q, data_strobe_d;
  logic [7:0]   last_byte_q, last_byte_d;
  logic         line_done_q, line_done_d;
  logic [7:0]   rd_ignored_q, rd_ignored_d;
`ifdef TLCD_CGRAM_EN
  logic [7:0]   cgram_q [64];
  logic [7:0]   cgram_d [64];
`endif

  // Decode one synchronized bus event into the next responder state.
  always_comb begin
    line0_d       = line0_q;
    line1_d       = line1_q;
    ac_d          = ac_q;
    incr_d        = incr_q;
    target_d      = target_q;
    display_on_d  = display_on_q;
    two_line_d    = two_line_q;
    cmd_strobe_d  = 1'b0;
    data_strobe_d = 1'b0;
    last_byte_d   = last_byte_q;
    line_done_d   = 1'b0;
    rd_ignored_d  = rd_ignored_q;
`ifdef TLCD_CGRAM_EN
    cgram_d       = cgram_q;
`endif
    if (bus_fall) begin
      if (bus_rw) begin
        if (rd_ignored_q != 8'hFF) rd_ignored_d = rd_ignored_q + 8'd1;
      end else if (!bus_rs) begin
        cmd_strobe_d = 1'b1;
        last_byte_d  = bus_data;
        if ((bus_data & CMD_DDADDR) != 8'h00) begin
          ac_d     = bus_data[6:0];
          target_d = TGT_DDRAM;
        end else if ((bus_data & CMD_CGADDR) != 8'h00) begin
          ac_d     = {1'b0, bus_data[5:0]};
          target_d = TGT_CGRAM;
        end else if ((bus_data & CMD_FUNC) != 8'h00) begin
          two_line_d = bus_data[FUNC_N_BIT];
        end else if ((bus_data & CMD_SHIFT) != 8'h00) begin
          if (!bus_data[SHIFT_S_BIT]) ac_d = next_ac(ac_q, bus_data[SHIFT_R_BIT], target_q);
        end else if ((bus_data & CMD_DISP) != 8'h00) begin
          display_on_d = bus_data[DISP_D_BIT];
        end else if ((bus_data & CMD_ENTRY) != 8'h00) begin
          incr_d = bus_data[ENTRY_I_BIT];
        end else if ((bus_data & CMD_HOME) != 8'h00) begin
          ac_d     = ROW0_BASE;
          target_d = TGT_DDRAM;
        end else if (bus_data == CMD_CLEAR) begin
          line0_d  = {LINE_CHARS{CHAR_SPACE}};
          line1_d  = {LINE_CHARS{CHAR_SPACE}};
          ac_d     = ROW0_BASE;
          incr_d   = 1'b1;
          target_d = TGT_DDRAM;
        end
      end else begin
        data_strobe_d = 1'b1;
        last_byte_d   = bus_data;
        if (target_q == TGT_DDRAM) begin
          for (int i = 0; i < LINE_CHARS; i++) begin
            if (ac_q[3:0] == 4'(i)) begin
              if (ac_q[6:4] == ROW0_BASE[6:4]) line0_d[8*(LINE_CHARS-1-i) +: 8] = bus_data;
              if (ac_q[6:4] == ROW1_BASE[6:4]) line1_d[8*(LINE_CHARS-1-i) +: 8] = bus_data;
            end
          end
          line_done_d = (ac_q == ROW0_BASE + 7'(LINE_CHARS - 1)) ||
                        (ac_q == ROW1_BASE + 7'(LINE_CHARS - 1));
        end else begin
`ifdef TLCD_CGRAM_EN
          cgram_d[ac_q[5:0]] = {3'b000, bus_data[4:0]};
`endif
        end
        ac_d = next_ac(ac_q, incr_q, target_q);
      end
    end
  end

  // Register all responder state; reset shows a blank display with AC at home.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      line0_q       <= {LINE_CHARS{CHAR_SPACE}};
      line1_q       <= {LINE_CHARS{CHAR_SPACE}};
      ac_q          <= ROW0_BASE;
      incr_q        <= 1'b1;
      target_q      <= TGT_DDRAM;
      display_on_q  <= 1'b0;
      two_line_q    <= 1'b0;
      cmd_strobe_q  <= 1'b0;
      data_strobe_q <= 1'b0;
      last_byte_q   <= 8'h00;
      line_done_q   <= 1'b0;
      rd_ignored_q  <= 8'h00;
`ifdef TLCD_CGRAM_EN
      for (int i = 0; i < 64; i++) cgram_q[i] <= 8'h00;
`endif
    end else begin
      line0_q       <= line0_d;
      line1_q       <= line1_d;
      ac_q          <= ac_d;
      incr_q        <= incr_d;
      target_q      <= target_d;
      display_on_q  <= display_on_d;
      two_line_q    <= two_line_d;
      cmd_strobe_q  <= cmd_strobe_d;
      data_strobe_q <= data_strobe_d;
      last_byte_q   <= last_byte_d;
      line_done_q   <= line_done_d;
      rd_ignored_q  <= rd_ignored_d;
`ifdef TLCD_CGRAM_EN
      for (int i = 0; i < 64; i++) cgram_q[i] <= cgram_d[i];
`endif
    end
  end

  assign LINE0       = line0_q;
  assign LINE1       = line1_q;
  assign AC          = ac_q;
  assign DISPLAY_ON  = display_on_q;
  assign TWO_LINE    = two_line_q;
  assign CMD_STROBE  = cmd_strobe_q;
  assign DATA_STROBE = data_strobe_q;
  assign LAST_BYTE   = last_byte_q;
  assign LINE_DONE   = line_done_q;
  assign RD_IGNORED  = rd_ignored_q;
`ifdef TLCD_CGRAM_EN
  assign CG_RDATA    = cgram_q[CG_RADDR];
`endif

endmodule
